phy_reset_transmitter: RTL and testbench
========================================

PHY_RESET_TRANSMITTER -- requirements
Module: phy_reset_transmitter

Interface
REQ-001 SHALL have parameter BIT_DIV, default 4: CLK cycles per transmitted bit, even, 2..255.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 1000: max CLK cycles waited for bus idle, 1..65535.
REQ-003 Port: CLK  input  1  single clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: iTRANSMIT  input  8  TRANSMIT register; [2:0]=101 hard reset, 110 cable reset.
REQ-006 Port: iTX_START  input  1  one-cycle strobe requesting transmission of iTRANSMIT[2:0].
REQ-007 Port: iBUS_IDLE  input  1  high when the CC line is idle.
REQ-008 Port: oTX_EN  output  1  driver enable, high while bits are on the line.
REQ-009 Port: oTX_BIT  output  1  serial line bit.
REQ-010 Port: PHY_ACK  output  1  one-cycle pulse, ordered set fully sent.
REQ-011 Port: oTX_FAIL  output  1  one-cycle pulse, bus never went idle within IDLE_TIMEOUT.
REQ-012 Port: oBUSY  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, WAIT_IDLE, PREAMBLE, ORDERED_SET, DONE, FAIL.
REQ-014 In IDLE, iTX_START=1 with iTRANSMIT[2:0] equal to 101 or 110 SHALL latch the command and move to WAIT_IDLE next cycle; any other value SHALL be ignored.
REQ-015 iTX_START outside IDLE SHALL be ignored; the latched command SHALL NOT change until return to IDLE.
REQ-016 WAIT_IDLE SHALL count cycles from 0; iBUS_IDLE=1 moves to PREAMBLE next cycle; count reaching IDLE_TIMEOUT with iBUS_IDLE=0 moves to FAIL.
REQ-017 If iBUS_IDLE=1 in the same cycle the count reaches IDLE_TIMEOUT, PREAMBLE SHALL win.
REQ-018 PREAMBLE SHALL send 64 alternating bits starting with 0, each held BIT_DIV cycles, oTX_EN=1 from the first preamble cycle.
REQ-019 ORDERED_SET SHALL send four 5-bit K-codes, bit 0 first, BIT_DIV cycles per bit, with no gap after the preamble.
REQ-020 K-code values: Sync-1=11000, Sync-3=00110, RST-1=00111, RST-2=11001 (written MSB..bit0).
REQ-021 Hard reset (101) SHALL send RST-1, RST-1, RST-1, RST-2; cable reset (110) SHALL send RST-1, Sync-1, RST-1, Sync-3.
REQ-022 Total oTX_EN high time SHALL be exactly 84*BIT_DIV cycles.
REQ-023 DONE SHALL last one cycle with oTX_EN=0 and PHY_ACK=1, then return to IDLE.
REQ-024 FAIL SHALL last one cycle with oTX_FAIL=1 and oTX_EN=0, then return to IDLE.
REQ-025 oTX_BIT SHALL be 0 whenever oTX_EN=0.
REQ-026 The bit-period and bit-index counters SHALL wrap to 0 at the end of each bit period and each field, respectively, with no lost or extra cycle.

Reset
REQ-027 While reset=0, the state SHALL be IDLE and oTX_EN, oTX_BIT, PHY_ACK, oTX_FAIL, oBUSY and all counters SHALL be 0, asynchronously.
REQ-028 Reset asserted mid-transmission SHALL drop oTX_EN immediately and SHALL produce no PHY_ACK or oTX_FAIL.
REQ-029 After reset deasserts, the first iTX_START SHALL be accepted no earlier than the following rising edge.

Configuration
REQ-030 Macro RESET_TX_BMC_EN: when defined, oTX_BIT SHALL be BMC-coded. The line toggles at every bit start and toggles again at cycle BIT_DIV/2 for a 1. The line level is 0 before the first bit.
REQ-031 When RESET_TX_BMC_EN is undefined, oTX_BIT SHALL be NRZ, equal to the data bit for the whole bit period.

Verification
REQ-032 Hard reset, NRZ, BIT_DIV=4: iTRANSMIT=0x05, strobe, iBUS_IDLE=1 -> oTX_EN high 336 cycles; bits 0101... x64 then 11100 11100 11100 10011; PHY_ACK pulses once.
REQ-033 Cable reset, NRZ: iTRANSMIT=0x06 -> after the preamble, bits 11100 00011 11100 01100; one PHY_ACK.
REQ-034 Timeout: IDLE_TIMEOUT=10, iBUS_IDLE=0 -> oTX_FAIL pulses once, 11 cycles after the strobe; oTX_EN never high.
REQ-035 Invalid command iTRANSMIT=0x03 with strobe -> oBUSY stays 0; no outputs toggle.
REQ-036 Reset asserted at bit 30 of the preamble -> oTX_EN=0 within the same cycle and no PHY_ACK. A new 0x05 strobe afterwards completes normally.
REQ-037 RESET_TX_BMC_EN defined, BIT_DIV=4, hard reset -> every bit boundary toggles; 1-bits toggle again at cycle 2; 84 bits; PHY_ACK once.

Source files
------------

// File: rtl/phy_reset_transmitter.sv
// Hard/cable reset ordered-set transmitter: waits for bus idle, then sends preamble + 4 K-codes.
// Define RESET_TX_BMC_EN for BMC line coding; the default build drives NRZ.
module phy_reset_transmitter #(
  parameter int unsigned BIT_DIV      = 4,
  parameter int unsigned IDLE_TIMEOUT = 1000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] iTRANSMIT,
  input  logic       iTX_START,
  input  logic       iBUS_IDLE,
  output logic       oTX_EN,
  output logic       oTX_BIT,
  output logic       PHY_ACK,
  output logic       oTX_FAIL,
  output logic       oBUSY
);

  typedef enum logic [2:0] {
    StIdle, StWaitIdle, StPreamble, StOrderedSet, StDone, StFail
  } state_e;

  localparam logic [4:0]  KSync1    = 5'b11000;
  localparam logic [4:0]  KSync3    = 5'b00110;
  localparam logic [4:0]  KRst1     = 5'b00111;
  localparam logic [4:0]  KRst2     = 5'b11001;
  // Field 0 sits in the low bits so the word is shifted out LSB first.
  localparam logic [19:0] OsHard    = {KRst2, KRst1, KRst1, KRst1};
  localparam logic [19:0] OsCable   = {KSync3, KRst1, KSync1, KRst1};
  localparam logic [7:0]  BitDivM1  = 8'(BIT_DIV - 1);
  localparam logic [15:0] TimeoutM1 = 16'(IDLE_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        cmd_hard_q, cmd_hard_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  field_q, field_d;

  logic        bit_end;
  logic        data_bit;
  logic        tx_en;
  logic        line_bit;
  logic [4:0]  os_pos;
  logic [19:0] os_word;
  logic        unused_transmit;

  assign unused_transmit = ^iTRANSMIT[7:3];
  assign bit_end = (bit_cnt_q == BitDivM1);
  assign os_pos  = 5'({3'b000, field_q} * 5'd5) + 5'(bit_idx_q);
  assign os_word = cmd_hard_q ? OsHard : OsCable;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cmd_hard_q <= 1'b0;
      wait_cnt_q <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      field_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_hard_q <= cmd_hard_d;
      wait_cnt_q <= wait_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      field_q    <= field_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_hard_d = cmd_hard_q;
    wait_cnt_d = wait_cnt_q;
    bit_cnt_d  = '0;
    bit_idx_d  = bit_idx_q;
    field_d    = field_q;
    data_bit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        wait_cnt_d = '0;
        bit_idx_d  = '0;
        field_d    = '0;
        if (iTX_START && (iTRANSMIT[2:0] == 3'b101 || iTRANSMIT[2:0] == 3'b110)) begin
          cmd_hard_d = (iTRANSMIT[2:0] == 3'b101);
          state_d    = StWaitIdle;
        end
      end
      StWaitIdle: begin
        // Bus idle takes priority over the timeout on the last counted cycle.
        if (iBUS_IDLE) begin
          state_d = StPreamble;
        end else if (wait_cnt_q == TimeoutM1) begin
          state_d = StFail;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StPreamble: begin
        data_bit  = bit_idx_q[0];
        bit_cnt_d = bit_end ? 8'd0 : bit_cnt_q + 8'd1;
        if (bit_end) begin
          if (bit_idx_q == 6'd63) begin
            bit_idx_d = '0;
            state_d   = StOrderedSet;
          end else begin
            bit_idx_d = bit_idx_q + 6'd1;
          end
        end
      end
      StOrderedSet: begin
        data_bit  = os_word[os_pos];
        bit_cnt_d = bit_end ? 8'd0 : bit_cnt_q + 8'd1;
        if (bit_end) begin
          if (bit_idx_q == 6'd4) begin
            bit_idx_d = '0;
            field_d   = field_q + 2'd1;
            if (field_q == 2'd3) begin
              state_d = StDone;
            end
          end else begin
            bit_idx_d = bit_idx_q + 6'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign tx_en = (state_q == StPreamble) || (state_q == StOrderedSet);

`ifdef RESET_TX_BMC_EN
  localparam logic [7:0] HalfDiv = 8'(BIT_DIV / 2);
  logic line_q, line_d;
  logic toggle;

  // line_q holds the level of the previous cycle; it rests at 0 between frames.
  assign toggle   = (bit_cnt_q == 8'd0) || ((bit_cnt_q == HalfDiv) && data_bit);
  assign line_bit = line_q ^ toggle;
  assign line_d   = tx_en ? line_bit : 1'b0;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      line_q <= 1'b0;
    end else begin
      line_q <= line_d;
    end
  end
`else
  assign line_bit = data_bit;
`endif

  assign oTX_EN   = tx_en;
  assign oTX_BIT  = tx_en & line_bit;
  assign PHY_ACK  = (state_q == StDone);
  assign oTX_FAIL = (state_q == StFail);
  assign oBUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_phy_reset_transmitter.sv
// Randomized bench for phy_reset_transmitter against a per-cycle waveform reference model.
module tb_phy_reset_transmitter;

  localparam int BD      = 4;
  localparam int IDLE_TO = 10;

  logic       CLK;
  logic       reset;
  logic [7:0] iTRANSMIT;
  logic       iTX_START;
  logic       iBUS_IDLE;
  logic       oTX_EN;
  logic       oTX_BIT;
  logic       PHY_ACK;
  logic       oTX_FAIL;
  logic       oBUSY;
  logic [4:0] obs;

  int n_cmp;
  int n_bad;

  phy_reset_transmitter #(
    .BIT_DIV      (BD),
    .IDLE_TIMEOUT (IDLE_TO)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .iTRANSMIT (iTRANSMIT),
    .iTX_START (iTX_START),
    .iBUS_IDLE (iBUS_IDLE),
    .oTX_EN    (oTX_EN),
    .oTX_BIT   (oTX_BIT),
    .PHY_ACK   (PHY_ACK),
    .oTX_FAIL  (oTX_FAIL),
    .oBUSY     (oBUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign obs = {oBUSY, oTX_EN, oTX_BIT, PHY_ACK, oTX_FAIL};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // K-code table, value written MSB..bit0.
  function automatic logic [4:0] kcode(input logic hard, input int f);
    if (hard) return (f == 3) ? 5'b11001 : 5'b00111;
    case (f)
      0:       return 5'b00111;
      1:       return 5'b11000;
      2:       return 5'b00111;
      default: return 5'b00110;
    endcase
  endfunction

  // Data bit number k (0..83) of the whole frame.
  function automatic logic frame_bit(input logic hard, input int k);
    logic [4:0] code;
    if (k < 64) return (k % 2) == 1;
    code = kcode(hard, (k - 64) / 5);
    return code[(k - 64) % 5];
  endfunction

  // Runs one command from strobe to return-to-idle; bus goes idle on wait cycle 'delay'.
  task automatic run_tx(input logic [7:0] cmd, input int delay);
    logic       valid;
    logic       hard;
    logic       lvl;
    logic       ebit;
    logic [4:0] exp;
    int         w;
    int         last;
    int         k;
    int         p;
    valid = (cmd[2:0] == 3'b101) || (cmd[2:0] == 3'b110);
    hard  = (cmd[2:0] == 3'b101);
    w     = 0;
    if (!valid) last = 20;
    else if (delay < IDLE_TO) begin
      w    = delay + 1;
      last = w + 84 * BD + 2;
    end else begin
      w    = IDLE_TO;
      last = w + 2;
    end
    lvl = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(posedge CLK);
      #1;
      if (c == 0) begin
        iTRANSMIT = cmd;
        iTX_START = 1'b1;
      end else begin
        iTRANSMIT = 8'($urandom);
        iTX_START = valid && (c < last) && ($urandom_range(0, 5) == 0);
      end
      if (valid && c >= 1 && c <= w) iBUS_IDLE = (c - 1 == delay);
      else iBUS_IDLE = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (!valid || c == 0 || c == last) exp = 5'b00000;
      else if (c <= w) exp = 5'b10000;
      else if (delay >= IDLE_TO) exp = 5'b10001;
      else if (c <= w + 84 * BD) begin
        k    = (c - w - 1) / BD;
        p    = (c - w - 1) % BD;
        ebit = frame_bit(hard, k);
`ifdef RESET_TX_BMC_EN
        if (p == 0) lvl = ~lvl;
        if (p == BD / 2 && ebit) lvl = ~lvl;
        ebit = lvl;
`endif
        exp = {2'b11, ebit, 2'b00};
      end else exp = 5'b10010;
      check_eq($sformatf("cmd%0h d%0d c%0d", cmd, delay, c), 32'(obs), 32'(exp));
    end
    iTX_START = 1'b0;
  endtask

  task automatic mid_reset();
    @(posedge CLK);
    #1;
    iTRANSMIT = 8'h05;
    iTX_START = 1'b1;
    iBUS_IDLE = 1'b1;
    @(posedge CLK);
    #1;
    iTX_START = 1'b0;
    repeat (1 + 30 * BD) @(posedge CLK);
    #2;
    check_eq("pre_reset_en", 32'(oTX_EN), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("async_drop", 32'(obs), 32'd0);
    repeat (3) begin
      @(negedge CLK);
      check_eq("in_reset", 32'(obs), 32'd0);
    end
    @(posedge CLK);
    #3;
    reset = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      check_eq("post_reset_quiet", 32'(obs), 32'd0);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    iTRANSMIT = 8'h00;
    iTX_START = 1'b0;
    iBUS_IDLE = 1'b0;
    #3;
    check_eq("reset_state", 32'(obs), 32'd0);
    repeat (3) @(posedge CLK);
    #3;
    reset = 1'b1;
    @(negedge CLK);
    check_eq("after_release", 32'(obs), 32'd0);

    run_tx(8'h05, 0);
    run_tx(8'h06, 0);
    run_tx(8'h06, 3);
    run_tx(8'h05, IDLE_TO - 1);
    run_tx(8'h05, IDLE_TO);
    run_tx(8'h06, 25);
    run_tx(8'h03, 0);
    run_tx(8'h00, 0);
    run_tx(8'hF5, 2);
    mid_reset();
    run_tx(8'h05, 0);

    for (int i = 0; i < 12; i++) begin
      logic [7:0] cmd;
      case ($urandom_range(0, 3))
        0:       cmd = {5'($urandom), 3'b101};
        1:       cmd = {5'($urandom), 3'b110};
        default: cmd = 8'($urandom);
      endcase
      run_tx(cmd, int'($urandom_range(0, 13)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
